srmem_drain: RTL and testbench

- Read-side consumer for the shift-register memory banks.
- Takes the head column (NUM_RDPORT lanes, each DATA_BW data bits plus a valid bit at the MSB) and issues column pops.
- Serializes the valid lanes of each column onto a single valid/ready stream, lowest lane first.
- After the last column of a batch, waits for the buffer's read-end indication and then requests the next batch.

---
 rtl/srmem_drain.sv | 154 +++++++++++++++
 tb/tb_srmem_drain.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srmem_drain.sv
// Read-side drain for the shift-register memory banks: pops one column at a time,
// streams its valid lanes lowest-first over valid/ready, then hands back for the next batch.
module srmem_drain #(
    parameter int NUM_RDPORT = 1,
    parameter int DATA_BW    = 8,
    parameter int CNT_BW     = 16,
    localparam int LANE_BW   = (NUM_RDPORT > 1) ? $clog2(NUM_RDPORT) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RDPORT*(DATA_BW+1)-1:0] dout_list,
    input  logic                              rdvalid,
    input  logic                              rdlast,
    input  logic                              rdend,
    output logic                              req_pop,
    output logic                              req_newdata,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_BW-1:0]                out_data,
    output logic [LANE_BW-1:0]                out_lane,
    output logic                              out_last,
    output logic [CNT_BW-1:0]                 elem_cnt,
    output logic                              busy
);

    // Output stream handshake: an element transfers on a cycle where out_valid and
    // out_ready are both high; while out_valid is high and out_ready low, out_data,
    // out_lane and out_last stay constant and out_valid does not drop.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [NUM_RDPORT*DATA_BW-1:0]   col_q;
    logic [NUM_RDPORT-1:0]           mask_q;
    logic                            last_q;

    logic [NUM_RDPORT*DATA_BW-1:0]   cap_data;
    logic [NUM_RDPORT-1:0]           cap_mask;
    logic [NUM_RDPORT-1:0]           low_oh;
    logic [NUM_RDPORT-1:0]           mask_next;
    logic [DATA_BW-1:0]              sel_data;
    logic [LANE_BW-1:0]              sel_lane;
    logic                            any_pending;
    logic                            single_pending;
    logic                            fire;
    logic                            load;
    logic                            clr_cnt;
    logic                            scan_valid;

    // Split the incoming column into packed payloads and a lane-valid mask.
    always_comb begin
        cap_data = '0;
        cap_mask = '0;
        for (int i = 0; i < NUM_RDPORT; i++) begin
            cap_mask[i]                    = dout_list[i*(DATA_BW+1) + DATA_BW];
            cap_data[i*DATA_BW +: DATA_BW] = dout_list[i*(DATA_BW+1) +: DATA_BW];
        end
    end

    // Isolate the lowest pending lane with two's-complement masking.
    assign low_oh         = mask_q & (~mask_q + NUM_RDPORT'(1));
    assign any_pending    = |mask_q;
    assign single_pending = any_pending && ((mask_q & (mask_q - NUM_RDPORT'(1))) == '0);

    always_comb begin
        sel_data = '0;
        sel_lane = '0;
        for (int i = 0; i < NUM_RDPORT; i++) begin
            if (low_oh[i]) begin
                sel_data = col_q[i*DATA_BW +: DATA_BW];
                sel_lane = LANE_BW'(i);
            end
        end
    end

    assign mask_next = fire ? (mask_q & ~low_oh) : mask_q;

    always_comb begin
        state_next  = state;
        req_pop     = 1'b0;
        req_newdata = 1'b0;
        scan_valid  = 1'b0;
        fire        = 1'b0;
        load        = 1'b0;
        clr_cnt     = 1'b0;
        case (state)
            IDLE: begin
                if (rdvalid) begin
                    req_pop    = 1'b1;
                    load       = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                scan_valid = any_pending;
                fire       = any_pending && out_ready;
                if (mask_next == '0) begin
                    state_next = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                if (rdend) begin
                    req_newdata = 1'b1;
                    clr_cnt     = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Nothing is requested or offered while reset is applied.
        if (rst) begin
            req_pop     = 1'b0;
            req_newdata = 1'b0;
            scan_valid  = 1'b0;
        end
    end

    assign out_valid = scan_valid;
    assign out_data  = scan_valid ? sel_data : '0;
    assign out_lane  = scan_valid ? sel_lane : '0;
    assign out_last  = scan_valid && last_q && single_pending;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            col_q    <= '0;
            mask_q   <= '0;
            last_q   <= 1'b0;
            elem_cnt <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                col_q  <= cap_data;
                mask_q <= cap_mask;
                last_q <= rdlast;
            end else begin
                mask_q <= mask_next;
            end
            // Count saturates so a runaway batch cannot wrap back to small values.
            if (clr_cnt) begin
                elem_cnt <= '0;
            end else if (fire && (elem_cnt != '1)) begin
                elem_cnt <= elem_cnt + CNT_BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_srmem_drain.sv
// Bench for srmem_drain: a column-buffer emulator feeds the DUT while a queue-based
// model predicts every output cycle; directed cases pin the model with literal values.
module tb_srmem_drain;

    localparam int NR   = 4;
    localparam int DB   = 8;
    localparam int CB   = 4;
    localparam int LB   = 2;
    localparam int LW   = DB + 1;
    localparam int DW   = NR * LW;
    localparam int EW   = 1 + LB + DB;
    localparam int CW   = 1 + DW;
    localparam int CMAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] dout_list;
    logic          rdvalid;
    logic          rdlast;
    logic          rdend;
    logic          req_pop;
    logic          req_newdata;
    logic          out_valid;
    logic          out_ready;
    logic [DB-1:0] out_data;
    logic [LB-1:0] out_lane;
    logic          out_last;
    logic [CB-1:0] elem_cnt;
    logic          busy;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    srmem_drain #(.NUM_RDPORT(NR), .DATA_BW(DB), .CNT_BW(CB)) dut (
        .clk(clk), .rst(rst), .dout_list(dout_list), .rdvalid(rdvalid), .rdlast(rdlast),
        .rdend(rdend), .req_pop(req_pop), .req_newdata(req_newdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
        .elem_cnt(elem_cnt), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- column buffer emulator / drivers ----------------
    logic [CW-1:0] col_fifo[$];
    logic          pop_seen   = 1'b0;
    bit            ready_rand = 1'b0;
    bit            rdend_rand = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (pop_seen && col_fifo.size() > 0) col_fifo.delete(0);
        if (col_fifo.size() > 0) begin
            rdvalid = 1'b1;
            {rdlast, dout_list} = col_fifo[0];
        end else begin
            rdvalid   = 1'b0;
            rdlast    = 1'b0;
            dout_list = '0;
        end
        if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
        if (rdend_rand) rdend = ($urandom_range(0, 3) == 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [CW-1:0] rand_col();
        logic [DW-1:0] d;
        logic          v;
        d = '0;
        for (int i = 0; i < NR; i++) begin
            v = ($urandom_range(0, 2) != 0);
            d[i*LW +: LW] = {v, DB'($urandom)};
        end
        v = ($urandom_range(0, 3) == 0);
        return {v, d};
    endfunction

    // ---------------- scoreboard / behavioural model ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] acc_q[$];
    longint        pop_times[$];
    int            m_phase = 0;   // 0 waiting for a column, 1 streaming a column, 2 waiting for batch end
    bit            m_last  = 1'b0;
    int            m_cnt   = 0;
    int            pop_cnt = 0;
    int            nd_cnt  = 0;
    int            cnt_at_nd = 0;
    longint        cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always begin : cmp
        logic [LW-1:0] ln;
        @(negedge clk);
        pop_seen = req_pop;
        if (rst) begin
            chk("rst_req_pop", 32'(req_pop), 32'(0));
            chk("rst_req_newdata", 32'(req_newdata), 32'(0));
            chk("rst_out_valid", 32'(out_valid), 32'(0));
            exp_q.delete();
            m_phase = 0;
            m_last  = 1'b0;
            m_cnt   = 0;
        end else begin
            chk("req_pop", 32'(req_pop), 32'(m_phase == 0 && rdvalid));
            chk("req_newdata", 32'(req_newdata), 32'(m_phase == 2 && rdend));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("elem_cnt", 32'(elem_cnt), 32'(m_cnt));
            if (m_phase == 1 && exp_q.size() > 0) begin
                chk("out_valid", 32'(out_valid), 32'(1));
                chk("out_data", 32'(out_data), 32'(exp_q[0][DB-1:0]));
                chk("out_lane", 32'(out_lane), 32'(exp_q[0][DB +: LB]));
                chk("out_last", 32'(out_last), 32'(exp_q[0][EW-1]));
            end else begin
                chk("out_valid", 32'(out_valid), 32'(0));
            end
            if (req_pop) begin
                pop_cnt++;
                pop_times.push_back(cyc);
            end
            if (req_newdata) begin
                nd_cnt++;
                cnt_at_nd = int'(elem_cnt);
            end
            if (out_valid && out_ready) acc_q.push_back({out_last, out_lane, out_data});
            case (m_phase)
                0: if (rdvalid) begin
                    for (int i = 0; i < NR; i++) begin
                        ln = dout_list[i*LW +: LW];
                        if (ln[DB]) exp_q.push_back({1'b0, LB'(i), ln[DB-1:0]});
                    end
                    if (rdlast && exp_q.size() > 0) exp_q[exp_q.size()-1][EW-1] = 1'b1;
                    m_last  = rdlast;
                    m_phase = 1;
                end
                1: begin
                    if (exp_q.size() > 0 && out_ready) begin
                        exp_q.delete(0);
                        if (m_cnt < CMAX) m_cnt++;
                    end
                    if (exp_q.size() == 0) m_phase = m_last ? 2 : 0;
                end
                default: if (rdend) begin
                    m_cnt   = 0;
                    m_phase = 0;
                end
            endcase
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(busy == 1'b0 && col_fifo.size() == 0 && rdvalid == 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n >= budget), 32'(0));
    endtask

    task automatic clear_logs();
        acc_q.delete();
        pop_times.delete();
        pop_cnt = 0;
        nd_cnt  = 0;
    endtask

    // ---------------- stimulus ----------------
    localparam logic [DW-1:0] COL_A  = {9'h1C3, 9'h155, 9'h0FF, 9'h1AA};
    localparam logic [DW-1:0] COL_C1 = {9'h0C3, 9'h055, 9'h0FF, 9'h0AA};
    localparam logic [DW-1:0] COL_C2 = {9'h011, 9'h022, 9'h142, 9'h033};
    localparam logic [DW-1:0] COL_D1 = {9'h1D4, 9'h033, 9'h044, 9'h1D1};
    localparam logic [DW-1:0] COL_D2 = {9'h000, 9'h000, 9'h1E2, 9'h000};
    localparam logic [DW-1:0] COL_D3 = {9'h104, 9'h103, 9'h102, 9'h101};
    localparam logic [DW-1:0] COL_E  = {9'h000, 9'h1B2, 9'h000, 9'h1B0};

    initial begin
        int n;
        int pops_before;
        int nd_before;
        int pushed;
        rst = 1'b1; rdend = 1'b0; out_ready = 1'b1;
        rdvalid = 1'b0; rdlast = 1'b0; dout_list = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("init_busy", 32'(busy), 32'(0));
        chk("init_elem_cnt", 32'(elem_cnt), 32'(0));
        chk("init_out_valid", 32'(out_valid), 32'(0));

        // Four-lane column, last of batch, rdend already high.
        tick();
        rdend = 1'b1;
        clear_logs();
        col_fifo.push_back({1'b1, COL_A});
        wait_idle("a_timeout", 40);
        chk("a_pops", 32'(pop_cnt), 32'(1));
        chk("a_newdata", 32'(nd_cnt), 32'(1));
        chk("a_nelem", 32'(acc_q.size()), 32'(3));
        if (acc_q.size() >= 3) begin
            chk("a_elem0", 32'(acc_q[0]), 32'({1'b0, 2'd0, 8'hAA}));
            chk("a_elem1", 32'(acc_q[1]), 32'({1'b0, 2'd2, 8'h55}));
            chk("a_elem2", 32'(acc_q[2]), 32'({1'b1, 2'd3, 8'hC3}));
        end
        chk("a_cnt_at_newdata", 32'(cnt_at_nd), 32'(3));
        chk("a_cnt_after", 32'(elem_cnt), 32'(0));

        // Backpressure on lane 2, then a long DONE wait with rdend low.
        tick();
        rdend = 1'b0;
        clear_logs();
        col_fifo.push_back({1'b1, COL_A});
        n = 0;
        @(negedge clk);
        while (!(out_valid && out_lane == 2'd0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b_lane0_timeout", 32'(n >= 20), 32'(0));
        tick();
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("b_hold_valid", 32'(out_valid), 32'(1));
            chk("b_hold_data", 32'(out_data), 32'(8'h55));
            chk("b_hold_lane", 32'(out_lane), 32'(2));
            chk("b_hold_cnt", 32'(elem_cnt), 32'(1));
        end
        tick();
        out_ready = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        chk("b_done_busy", 32'(busy), 32'(1));
        chk("b_no_newdata", 32'(nd_cnt), 32'(0));
        chk("b_pops", 32'(pop_cnt), 32'(1));
        chk("b_cnt_in_done", 32'(elem_cnt), 32'(3));
        tick();
        rdend = 1'b1;
        wait_idle("b_timeout", 20);
        repeat (3) tick();
        chk("b_newdata", 32'(nd_cnt), 32'(1));
        chk("b_pops_after", 32'(pop_cnt), 32'(1));
        chk("b_cnt_after", 32'(elem_cnt), 32'(0));

        // All-invalid non-last column followed by a single-lane last column.
        tick();
        clear_logs();
        col_fifo.push_back({1'b0, COL_C1});
        col_fifo.push_back({1'b1, COL_C2});
        wait_idle("c_timeout", 40);
        chk("c_pops", 32'(pop_cnt), 32'(2));
        chk("c_nelem", 32'(acc_q.size()), 32'(1));
        if (acc_q.size() >= 1) chk("c_elem0", 32'(acc_q[0]), 32'({1'b1, 2'd1, 8'h42}));

        // Three back-to-back non-last columns: spacing and accumulation.
        tick();
        clear_logs();
        col_fifo.push_back({1'b0, COL_D1});
        col_fifo.push_back({1'b0, COL_D2});
        col_fifo.push_back({1'b0, COL_D3});
        wait_idle("d_timeout", 60);
        chk("d_pops", 32'(pop_cnt), 32'(3));
        if (pop_times.size() >= 3) begin
            chk("d_gap1", 32'(pop_times[1] - pop_times[0]), 32'(3));
            chk("d_gap2", 32'(pop_times[2] - pop_times[1]), 32'(2));
        end
        chk("d_nelem", 32'(acc_q.size()), 32'(7));
        chk("d_elem_cnt", 32'(elem_cnt), 32'(7));
        chk("d_newdata", 32'(nd_cnt), 32'(0));

        // Reset while two lanes are still pending.
        tick();
        out_ready = 1'b0;
        col_fifo.push_back({1'b0, COL_E});
        n = 0;
        @(negedge clk);
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("e_busy_timeout", 32'(n >= 10), 32'(0));
        chk("e_valid_before", 32'(out_valid), 32'(1));
        chk("e_data_before", 32'(out_data), 32'(8'hB0));
        chk("e_cnt_before", 32'(elem_cnt), 32'(7));
        pops_before = pop_cnt;
        nd_before   = nd_cnt;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("e_valid_after", 32'(out_valid), 32'(0));
        chk("e_busy_after", 32'(busy), 32'(0));
        chk("e_cnt_after", 32'(elem_cnt), 32'(0));
        chk("e_no_pop", 32'(pop_cnt), 32'(pops_before));
        chk("e_no_newdata", 32'(nd_cnt), 32'(nd_before));
        tick();
        out_ready = 1'b1;

        // Randomised columns, backpressure and batch-end timing.
        ready_rand = 1'b1;
        rdend_rand = 1'b1;
        pushed = 0;
        for (int c = 0; c < 4000 && pushed < 80; c++) begin
            if (col_fifo.size() < 2) begin
                col_fifo.push_back(rand_col());
                pushed++;
            end
            tick();
        end
        ready_rand = 1'b0;
        rdend_rand = 1'b0;
        tick();
        out_ready = 1'b1;
        rdend     = 1'b1;
        wait_idle("rand_drain_timeout", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
